// File: rtl/uart_rx.sv
// UART receiver: free-running 16x baud-tick generator feeding a start/data/stop FSM.
// Frames are LSB first with one start bit, NB_DATA data bits, one unchecked stop bit.
module uart_rx #(
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned CLK_FREC  = 50000000,
  parameter int unsigned NB_DATA   = 8,
  parameter int unsigned SB_TICK   = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic               o_tick,
  output logic               o_rx_done_tick,
  output logic [NB_DATA-1:0] o_data
);

  localparam int unsigned MCalc = CLK_FREC / (BAUD_RATE * 16);
  localparam int unsigned M     = (MCalc < 1) ? 1 : MCalc;
  localparam int unsigned CW    = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned NW    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [CW-1:0] TickMax = CW'(M - 1);
  localparam logic [NW-1:0] NLast   = NW'(NB_DATA - 1);
  localparam logic [3:0]    SLast   = 4'(SB_TICK - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [CW-1:0]      r_tick_cnt;
  logic               w_tick;
  logic               r_rx_meta;
  logic               r_rx_s;
  state_e             r_state;
  state_e             w_state_nxt;
  logic [3:0]         r_s;
  logic [3:0]         w_s_nxt;
  logic [NW-1:0]      r_n;
  logic [NW-1:0]      w_n_nxt;
  logic [NB_DATA-1:0] r_b;
  logic [NB_DATA-1:0] w_b_nxt;
  logic               w_done;

  // Free-running; never resynchronized to the start edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TickMax) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CW'(1);
    end
  end

  assign w_tick = (r_tick_cnt == TickMax);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_done      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!r_rx_s) begin
          w_state_nxt = StStart;
          w_s_nxt     = '0;
        end
      end
      StStart: begin
        // Mid-start-bit sample rejects glitches shorter than half a bit.
        if (w_tick) begin
          if (r_s == 4'd7) begin
            if (!r_rx_s) begin
              w_state_nxt = StData;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = StIdle;
            end
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
      end
      StData: begin
        if (w_tick) begin
          if (r_s == 4'd15) begin
            w_s_nxt = '0;
            w_b_nxt = {r_rx_s, r_b[NB_DATA-1:1]};
            if (r_n == NLast) begin
              w_state_nxt = StStop;
            end else begin
              w_n_nxt = r_n + NW'(1);
            end
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
      end
      StStop: begin
        if (w_tick) begin
          if (r_s == SLast) begin
            w_state_nxt = StIdle;
            w_done      = 1'b1;
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_tick         = w_tick;
  assign o_rx_done_tick = w_done;
  assign o_data         = r_b;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a fast-baud instance receives directed frames, and a
// default-parameter instance is used to measure the oversampling tick.
module tb_uart_rx;

  localparam int BitCyc = 433;  // 27-cycle tick x16 = 432, line slightly slow

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic       rx_idle;
  logic       tick;
  logic       done;
  logic [7:0] data;
  logic       dflt_tick;
  logic       dflt_done;
  logic [7:0] dflt_data;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  always #10 clk = ~clk;

  uart_rx #(
    .BAUD_RATE(115200),
    .CLK_FREC (50000000),
    .NB_DATA  (8),
    .SB_TICK  (16)
  ) u_dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_rx          (i_rx),
    .o_tick        (tick),
    .o_rx_done_tick(done),
    .o_data        (data)
  );

  uart_rx u_dflt (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_rx          (rx_idle),
    .o_tick        (dflt_tick),
    .o_rx_done_tick(dflt_done),
    .o_data        (dflt_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // line[0] is the start bit, line[9] the stop bit; total may truncate the frame.
  task automatic send_line(input logic [9:0] line, input int total);
    for (int c = 0; c < total; c++) begin
      i_rx = line[c / BitCyc];
      @(negedge clk);
    end
    i_rx = 1'b1;
  endtask

  // Monitor: pops one expected byte per done pulse, and checks the pulse is one cycle wide.
  initial begin
    logic       prev_done;
    logic [7:0] exp_b;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) check("done_width", done, 1'b0);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got pulse with data %0h, expected none (t=%0t)",
                   data, $time);
        end else begin
          exp_b = exp_q.pop_front();
          check("rx_data", data, exp_b);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    int c;
    i_reset = 1'b0;
    i_rx    = 1'b1;
    rx_idle = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tick", tick, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_dflt_tick", dflt_tick, 1'b0);
    check("rst_dflt_done", dflt_done, 1'b0);
    check("rst_dflt_data", dflt_data, 8'h00);

    // The release cycle counts as cycle 1; the tick lands in cycle 325.
    i_reset = 1'b1;
    c = 1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      c++;
      if (dflt_tick) break;
    end
    check("first_tick_cycle", c, 325);
    for (int p = 0; p < 2; p++) begin
      c = 0;
      for (int k = 0; k < 2000; k++) begin
        @(negedge clk);
        c++;
        if (k == 0) check("tick_width", dflt_tick, 1'b0);
        if (dflt_tick) break;
      end
      check("tick_period", c, 325);
    end

    // 8'hE5: line 0,1,0,1,0,0,1,1,1,1
    exp_q.push_back(8'hE5);
    send_line(10'b1111001010, 10 * BitCyc);

    exp_q.push_back(8'h00);
    send_line(10'b1000000000, 10 * BitCyc);
    exp_q.push_back(8'hFF);
    send_line(10'b1111111110, 10 * BitCyc);

    // Two-tick start glitch must be rejected and leave the last word intact.
    i_rx = 1'b0;
    repeat (54) @(negedge clk);
    i_rx = 1'b1;
    repeat (3 * BitCyc) @(negedge clk);
    check("glitch_data_hold", data, 8'hFF);

    // 8'h5A cut during its 4th data bit by reset.
    send_line(10'b1010110100, 4 * BitCyc + BitCyc / 2);
    i_reset = 1'b0;
    @(negedge clk);
    check("abort_rst_data", data, 8'h00);
    check("abort_rst_done", done, 1'b0);
    repeat (5) @(negedge clk);
    i_reset = 1'b1;
    repeat (2 * BitCyc) @(negedge clk);

    exp_q.push_back(8'hA5);
    send_line(10'b1101001010, 10 * BitCyc);

    // 8'h3C with a low stop bit, held low just long enough to cover the done pulse.
    exp_q.push_back(8'h3C);
    send_line(10'b0001111000, 9 * BitCyc + 300);
    repeat (3 * BitCyc) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_RATE, default 9600, serial bit rate in bits/s.
REQ-002 Parameter CLK_FREC, default 50000000, i_clk frequency in Hz.
REQ-003 Parameter NB_DATA, default 8, data bits per frame.
REQ-004 Parameter SB_TICK, default 16, oversampling ticks spent in the stop bit.
REQ-005 i_clk  input  1  single clock; all logic on rising edge.
REQ-006 i_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 i_rx  input  1  serial line; idle high; LSB first; 1 start bit, NB_DATA data bits, 1 stop bit, no parity.
REQ-008 o_tick  output  1  16x-oversampling strobe, one i_clk cycle wide.
REQ-009 o_rx_done_tick  output  1  one-cycle pulse when a frame completes.
REQ-010 o_data  output  NB_DATA  last received data word.

Function
REQ-011 The block SHALL contain a baud-tick generator and a receiver FSM; the receiver SHALL advance only on cycles where o_tick=1.
REQ-012 Divisor M SHALL be CLK_FREC/(BAUD_RATE*16), truncated (325 at defaults); minimum M is 1.
REQ-013 The tick counter SHALL count 0..M-1 and wrap to 0; o_tick SHALL be 1 exactly in the cycle the counter equals M-1.
REQ-014 At defaults, o_tick SHALL have a period of 325 cycles (6500 ns); 16 ticks = 104000 ns per bit.
REQ-015 i_rx SHALL pass through a two-flop synchronizer (reset value 1) before the FSM; the synchronized value is rx_s.
REQ-016 FSM states: IDLE, START, DATA, STOP; registers: tick count s (4 bits), bit count n (clog2(NB_DATA) bits), shift register b (NB_DATA bits).
REQ-017 IDLE: when rx_s=0 (no tick needed), go to START and clear s.
REQ-018 START: on each tick increment s; when s=7 on a tick, if rx_s=0 go to DATA with s=0, n=0; if rx_s=1 (glitch) return to IDLE.
REQ-019 DATA: on each tick increment s; when s=15 on a tick, set s=0 and b={rx_s, b[NB_DATA-1:1]}; if n=NB_DATA-1 go to STOP, else increment n.
REQ-020 STOP: on each tick increment s; when s=SB_TICK-1 on a tick, go to IDLE and pulse o_rx_done_tick for exactly one cycle.
REQ-021 The stop-bit value SHALL NOT be checked; the frame completes regardless of rx_s in STOP.
REQ-022 o_data SHALL continuously reflect b and SHALL hold its value between frames; it updates only by shifting in DATA.
REQ-023 A new start edge SHALL be accepted from IDLE in the cycle after o_rx_done_tick; back-to-back frames SHALL be received without loss.
REQ-024 Ticks arriving in IDLE SHALL be ignored; the tick counter SHALL free-run and not resynchronize to the start edge.

Reset
REQ-025 While i_reset=0: FSM=IDLE, s=0, n=0, b=0, tick counter=0, synchronizer flops=1, o_tick=0, o_rx_done_tick=0, o_data=0.
REQ-026 Reset SHALL take effect immediately, including mid-frame, discarding the partial frame without asserting o_rx_done_tick.
REQ-027 After release, the first o_tick SHALL occur M cycles later, and the FSM SHALL wait in IDLE for a falling edge.

Verification
REQ-028 Defaults, 20 ns clock: measure o_tick -> 1-cycle pulses every 325 cycles, first pulse 325 cycles after reset release.
REQ-029 Frame 8'hE5 (line sequence 0,1,0,1,0,0,1,1,1,1 at 104160 ns/bit) -> single o_rx_done_tick pulse with o_data=8'hE5, within the stop bit.
REQ-030 Back-to-back frames 8'h00 then 8'hFF -> two done pulses with o_data 8'h00, then 8'hFF.
REQ-031 i_rx low pulse of 2 ticks, then high -> FSM returns to IDLE; no done pulse; o_data unchanged.
REQ-032 Reset asserted during the 4th data bit, released, then frame 8'hA5 sent -> no pulse for the aborted frame; o_data=8'h00 during reset; next pulse with o_data=8'hA5.
REQ-033 Stop bit driven 0 on frame 8'h3C -> done pulse still asserted with o_data=8'h3C.
